// File: rtl/qtcore_pkg.sv
// qtcore_pkg: shared constants for the qtcore-A1 class accumulator CPU.
//   - datapath widths (PC_W, DATA_W, ADDR_W)
//   - one-hot control state encodings
//   - opcode nibbles and F-group sub-codes
// Optional feature macro used by the top: QTCORE_SHIFT_OPS_EN.
package qtcore_pkg;

    localparam int PC_W   = 5;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int ST_W   = 3;

    typedef enum logic [ST_W-1:0] {
        ST_FETCH = 3'b001,
        ST_EXEC  = 3'b010,
        ST_HALT  = 3'b100
    } state_e;

    // High nibble of IR
    localparam logic [3:0] OP_LDA  = 4'h0;
    localparam logic [3:0] OP_STA  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOP  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_BNZ  = 4'hA;
    localparam logic [3:0] OP_LDI  = 4'hD;
    localparam logic [3:0] OP_ADDI = 4'hE;
    localparam logic [3:0] OP_FGRP = 4'hF;

    // Low nibble when the high nibble is OP_FGRP
    localparam logic [3:0] FN_HLT = 4'h0;
    localparam logic [3:0] FN_CLR = 4'h1;
    localparam logic [3:0] FN_NOT = 4'h2;
    localparam logic [3:0] FN_SHL = 4'h3;
    localparam logic [3:0] FN_SHR = 4'h4;

endpackage

// File: rtl/kiwih_qtcore_tt_scan_cell_reg.sv
// scan_cell_reg: a WIDTH-bit register that is also a segment of a serial
// scan chain. Bits shift in at bit 0 and leave from bit WIDTH-1.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset, loads rst_value
//   rst_value - value loaded on reset
//   scan_en   - shift one position toward the MSB, taking scan_in at bit 0
//   scan_in   - serial input from the previous segment
//   scan_out  - serial output (current MSB) to the next segment
//   load_en   - parallel load of d
//   d, q      - parallel data in / register contents
// Priority per edge: rst > scan_en > load_en > hold.
module scan_cell_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_value,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
    input  logic             load_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= rst_value;
        end else if (scan_en) begin
            // Shift form that stays legal for WIDTH == 1
            r_q <= (r_q << 1) | WIDTH'(scan_in);
        end else if (load_en) begin
            r_q <= d;
        end
    end

    assign q        = r_q;
    assign scan_out = r_q[WIDTH-1];

endmodule

// File: rtl/kiwih_qtcore_tt_top.sv
// kiwih_qtcore_tt_top: TinyTapeout-style wrapper around a small 8-bit
// accumulator CPU whose entire state (state, PC, IR, ACC, memory) is one
// serial scan chain, so a host loads programs and reads results over 3 pins.
// Ports:
//   io_in[0]   clk (rising edge)
//   io_in[1]   rst, synchronous active-high
//   io_in[2]   scan_enable_n, active-low: shift the chain
//   io_in[3]   proc_en_n, active-low: let the CPU step
//   io_in[4]   scan_in
//   io_in[7:5] unused
//   io_out[0]  halt (state == HALT)
//   io_out[6:1] MEM[15][5:0]
//   io_out[7]  scan_out (MSB of MEM[MEM_SIZE-1])
// Chain order, LSB first: state, PC, IR, ACC, MEM[0] .. MEM[MEM_SIZE-1].
// Optional macro QTCORE_SHIFT_OPS_EN: when defined, F3/F4 are SHL/SHR;
// otherwise they are NOPs and no shifter exists.
import qtcore_pkg::*;

module kiwih_qtcore_tt_top #(
    parameter int MEM_SIZE = 20
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic clk;
    logic w_rst;
    logic w_scan_en;
    logic w_cpu_en;
    logic w_unused;

    assign clk       = io_in[0];
    assign w_rst     = io_in[1];
    assign w_scan_en = ~io_in[2];
    // Scan outranks the CPU; the cells already enforce rst on top of that
    assign w_cpu_en  = ~io_in[3] & ~w_scan_en;
    assign w_unused  = &{1'b0, io_in[7:5]};

    logic [ST_W-1:0]   w_state, w_state_next;
    logic [PC_W-1:0]   w_pc, w_pc_next;
    logic [DATA_W-1:0] w_ir, w_ir_next;
    logic [DATA_W-1:0] w_acc, w_acc_next;
    logic [DATA_W-1:0] w_mem [MEM_SIZE];
    logic              w_mem_we;

    logic              w_state_so, w_pc_so, w_ir_so;
    logic [MEM_SIZE:0] w_mem_link;

    logic [3:0]        w_op;
    logic [ADDR_W-1:0] w_op_addr;
    logic [DATA_W-1:0] w_operand;
    logic [DATA_W-1:0] w_fetch_byte;

    assign w_op      = w_ir[7:4];
    assign w_op_addr = w_ir[3:0];

    // Architectural registers, chained in V order
    scan_cell_reg #(.WIDTH(ST_W)) u_state (
        .clk(clk), .rst(w_rst), .rst_value(ST_FETCH),
        .scan_en(w_scan_en), .scan_in(io_in[4]), .scan_out(w_state_so),
        .load_en(w_cpu_en), .d(w_state_next), .q(w_state)
    );

    scan_cell_reg #(.WIDTH(PC_W)) u_pc (
        .clk(clk), .rst(w_rst), .rst_value('0),
        .scan_en(w_scan_en), .scan_in(w_state_so), .scan_out(w_pc_so),
        .load_en(w_cpu_en), .d(w_pc_next), .q(w_pc)
    );

    scan_cell_reg #(.WIDTH(DATA_W)) u_ir (
        .clk(clk), .rst(w_rst), .rst_value('0),
        .scan_en(w_scan_en), .scan_in(w_pc_so), .scan_out(w_ir_so),
        .load_en(w_cpu_en), .d(w_ir_next), .q(w_ir)
    );

    scan_cell_reg #(.WIDTH(DATA_W)) u_acc (
        .clk(clk), .rst(w_rst), .rst_value('0),
        .scan_en(w_scan_en), .scan_in(w_ir_so), .scan_out(w_mem_link[0]),
        .load_en(w_cpu_en), .d(w_acc_next), .q(w_acc)
    );

    // Memory bytes are never reset; reset still has to win over both shift
    // and store, so those enables are masked with rst here.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_SIZE; gi++) begin : g_mem
            scan_cell_reg #(.WIDTH(DATA_W)) u_byte (
                .clk      (clk),
                .rst      (1'b0),
                .rst_value('0),
                .scan_en  (w_scan_en & ~w_rst),
                .scan_in  (w_mem_link[gi]),
                .scan_out (w_mem_link[gi+1]),
                .load_en  (w_cpu_en & ~w_rst & w_mem_we & (32'(w_op_addr) == gi)),
                .d        (w_acc),
                .q        (w_mem[gi])
            );
        end
    endgenerate

    // Read ports: fetch by PC (bytes past MEM_SIZE read as 0) and operand by
    // the 4-bit address field (always inside memory since MEM_SIZE >= 16).
    always_comb begin
        w_fetch_byte = '0;
        w_operand    = '0;
        for (int k = 0; k < MEM_SIZE; k++) begin
            if (32'(w_pc) == k) w_fetch_byte = w_mem[k];
            if (32'(w_op_addr) == k) w_operand = w_mem[k];
        end
    end

    // Next-state / datapath logic
    always_comb begin
        w_state_next = w_state;
        w_pc_next    = w_pc;
        w_ir_next    = w_ir;
        w_acc_next   = w_acc;
        w_mem_we     = 1'b0;

        case (w_state)
            ST_FETCH: begin
                w_ir_next    = w_fetch_byte;
                w_pc_next    = w_pc + 5'd1;
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_next = ST_FETCH;
                case (w_op)
                    OP_LDA:  w_acc_next = w_operand;
                    OP_STA:  w_mem_we   = 1'b1;
                    OP_ADD:  w_acc_next = w_acc + w_operand;
                    OP_SUB:  w_acc_next = w_acc - w_operand;
                    OP_AND:  w_acc_next = w_acc & w_operand;
                    OP_OR:   w_acc_next = w_acc | w_operand;
                    OP_XOR:  w_acc_next = w_acc ^ w_operand;
                    OP_JMP:  w_pc_next  = {1'b0, w_op_addr};
                    OP_BZ:   if (w_acc == '0) w_pc_next = {1'b0, w_op_addr};
                    OP_BNZ:  if (w_acc != '0) w_pc_next = {1'b0, w_op_addr};
                    OP_LDI:  w_acc_next = {4'b0000, w_op_addr};
                    OP_ADDI: w_acc_next = w_acc + {4'b0000, w_op_addr};
                    OP_FGRP: begin
                        case (w_op_addr)
                            FN_HLT: w_state_next = ST_HALT;
                            FN_CLR: w_acc_next   = '0;
                            FN_NOT: w_acc_next   = ~w_acc;
`ifdef QTCORE_SHIFT_OPS_EN
                            FN_SHL: w_acc_next   = {w_acc[DATA_W-2:0], 1'b0};
                            FN_SHR: w_acc_next   = {1'b0, w_acc[DATA_W-1:1]};
`endif
                            default: ;
                        endcase
                    end
                    default: ;  // 7, B, C: NOP
                endcase
            end
            ST_HALT: ;
            default: w_state_next = ST_FETCH;  // recover from illegal encodings
        endcase
    end

    assign io_out[0]   = (w_state == ST_HALT);
    assign io_out[6:1] = w_mem[15][5:0];
    assign io_out[7]   = w_mem_link[MEM_SIZE];

endmodule

// File: tb/tb_kiwih_qtcore_tt_top.sv
// Directed testbench for kiwih_qtcore_tt_top (MEM_SIZE = 20, chain = 184).
module tb_kiwih_qtcore_tt_top;

    localparam int MEM_SIZE = 20;
    localparam int CHAIN    = 24 + 8 * MEM_SIZE;

`ifdef QTCORE_SHIFT_OPS_EN
    localparam logic [7:0] ALU_RESULT = 8'h6C;
`else
    localparam logic [7:0] ALU_RESULT = 8'h36;
`endif

    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic scan_en_n = 1'b1;
    logic proc_en_n = 1'b1;
    logic scan_in   = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int checks = 0;
    int errors = 0;

    logic [CHAIN-1:0] cap;
    logic [7:0]       img [MEM_SIZE];

    assign io_in = {3'b000, scan_in, proc_en_n, scan_en_n, rst, clk};

    always #5 clk = ~clk;

    kiwih_qtcore_tt_top #(.MEM_SIZE(MEM_SIZE)) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_img();
        for (int k = 0; k < MEM_SIZE; k++) img[k] = 8'h00;
    endtask

    function automatic logic [CHAIN-1:0] build(input logic [2:0] st, input logic [4:0] pc,
                                               input logic [7:0] ir, input logic [7:0] acc);
        logic [CHAIN-1:0] v;
        v        = '0;
        v[2:0]   = st;
        v[7:3]   = pc;
        v[15:8]  = ir;
        v[23:16] = acc;
        for (int k = 0; k < MEM_SIZE; k++) v[24 + 8*k +: 8] = img[k];
        return v;
    endfunction

    task automatic scan_load(input logic [CHAIN-1:0] vec);
        scan_en_n = 1'b0;
        for (int i = CHAIN - 1; i >= 0; i--) begin
            scan_in = vec[i];
            tick(1);
        end
        scan_en_n = 1'b1;
        scan_in   = 1'b0;
    endtask

    task automatic scan_unload();
        scan_en_n = 1'b0;
        scan_in   = 1'b0;
        for (int i = CHAIN - 1; i >= 0; i--) begin
            cap[i] = io_out[7];
            tick(1);
        end
        scan_en_n = 1'b1;
    endtask

    task automatic run(input int n);
        proc_en_n = 1'b0;
        tick(n);
        proc_en_n = 1'b1;
    endtask

    task automatic check_regs(input string tag, input logic [2:0] st, input logic [4:0] pc,
                              input logic [7:0] ir, input logic [7:0] acc);
        check({tag, ".state"}, dut.w_state, st);
        check({tag, ".pc"},    dut.w_pc,    pc);
        check({tag, ".ir"},    dut.w_ir,    ir);
        check({tag, ".acc"},   dut.w_acc,   acc);
    endtask

    logic [7:0] br_acc [5] = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h05};
    logic [7:0] br_ins [5] = '{8'h98, 8'h98, 8'hA7, 8'hA7, 8'h83};
    logic [4:0] br_pc  [5] = '{5'd8,  5'd1,  5'd7,  5'd1,  5'd3};

    initial begin
        #1;
        // Reset
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_regs("reset", 3'b001, 5'd0, 8'h00, 8'h00);
        check("reset.halt", io_out[0], 1'b0);

        // Scan load
        clear_img();
        for (int k = 0; k < 5; k++) img[k] = 8'hE0 + 8'(k);
        scan_load(build(3'b001, 5'd1, 8'hE0, 8'h01));
        check_regs("load", 3'b001, 5'd1, 8'hE0, 8'h01);
        check("load.mem0", dut.w_mem[0], 8'hE0);
        check("load.mem4", dut.w_mem[4], 8'hE4);
        check("load.mem19", dut.w_mem[19], 8'h00);

        // Four ADDIs: 1+1+2+3+4 = 0x0B
        run(8);
        check_regs("run", 3'b001, 5'd5, 8'hE4, 8'h0B);

        // Unload
        scan_unload();
        check("unload.state", cap[2:0], 3'b001);
        check("unload.pc", cap[7:3], 5'h05);
        check("unload.ir", cap[15:8], 8'hE4);
        check("unload.acc", cap[23:16], 8'h0B);
        for (int k = 0; k < 5; k++)
            check($sformatf("unload.mem%0d", k), cap[24 + 8*k +: 8], 8'hE0 + 8'(k));
        check("unload.mem15", cap[24 + 8*15 +: 8], 8'h00);

        // Chain is now all zero: illegal state recovers to FETCH
        check("zero.state", dut.w_state, 3'b000);
        run(1);
        check("illegal.state", dut.w_state, 3'b001);
        check("illegal.pc", dut.w_pc, 5'd0);

        // LDI 5 ; STA 15 ; HLT
        clear_img();
        img[0] = 8'hD5; img[1] = 8'h1F; img[2] = 8'hF0;
        scan_load(build(3'b001, 5'd0, 8'h00, 8'h00));
        run(6);
        check("prog.out", io_out[6:1], 6'd5);
        check("prog.halt", io_out[0], 1'b1);
        run(3);
        check("halted.out", io_out[6:1], 6'd5);
        check("halted.halt", io_out[0], 1'b1);
        check("halted.pc", dut.w_pc, 5'd3);

        // ALU chain: LDI 9, ADD, SUB, AND, OR, XOR, NOT, F3, STA 15, HLT
        clear_img();
        img[0] = 8'hD9; img[1] = 8'h2A; img[2] = 8'h3B; img[3] = 8'h4C;
        img[4] = 8'h5D; img[5] = 8'h6E; img[6] = 8'hF2; img[7] = 8'hF3;
        img[8] = 8'h1F; img[9] = 8'hF0;
        img[10] = 8'h10; img[11] = 8'h03; img[12] = 8'h0F; img[13] = 8'h30; img[14] = 8'hFF;
        scan_load(build(3'b001, 5'd0, 8'h00, 8'h00));
        run(20);
        check("alu.acc", dut.w_acc, ALU_RESULT);
        check("alu.mem15", dut.w_mem[15], ALU_RESULT);
        check("alu.out", io_out[6:1], ALU_RESULT[5:0]);
        check("alu.halt", io_out[0], 1'b1);

        // LDA, SUB wrap, ADDI wrap, BZ taken
        clear_img();
        img[0] = 8'h0A; img[1] = 8'h3B; img[2] = 8'hE1; img[3] = 8'h96;
        img[4] = 8'hF1; img[5] = 8'hF1; img[6] = 8'hF0;
        img[10] = 8'h01; img[11] = 8'h02;
        scan_load(build(3'b001, 5'd0, 8'h00, 8'h00));
        run(4);
        check("wrap.sub", dut.w_acc, 8'hFF);
        run(4);
        check_regs("wrap", 3'b001, 5'd6, 8'h96, 8'h00);
        run(2);
        check("wrap.halt", io_out[0], 1'b1);

        // Branch table
        for (int t = 0; t < 5; t++) begin
            clear_img();
            img[0] = br_ins[t];
            scan_load(build(3'b001, 5'd0, 8'h00, br_acc[t]));
            run(2);
            check($sformatf("branch%0d.pc", t), dut.w_pc, br_pc[t]);
        end

        // Fetch past memory reads 0; PC wraps at 5 bits
        clear_img();
        img[0] = 8'h77;
        scan_load(build(3'b001, 5'd20, 8'hAA, 8'h33));
        run(1);
        check_regs("fetch20", 3'b010, 5'd21, 8'h00, 8'h33);
        scan_load(build(3'b001, 5'd31, 8'hAA, 8'h33));
        run(1);
        check_regs("fetch31", 3'b010, 5'd0, 8'h00, 8'h33);

        // Reset during EXEC of STA 15: abandoned, memory untouched
        clear_img();
        img[0] = 8'h1F; img[15] = 8'h11;
        scan_load(build(3'b001, 5'd0, 8'h00, 8'h2A));
        run(1);
        check("prerst.state", dut.w_state, 3'b010);
        rst = 1'b1;
        proc_en_n = 1'b0;
        tick(1);
        rst = 1'b0;
        proc_en_n = 1'b1;
        check_regs("rstexec", 3'b001, 5'd0, 8'h00, 8'h00);
        check("rstexec.mem15", dut.w_mem[15], 8'h11);
        check("rstexec.mem0", dut.w_mem[0], 8'h1F);

        // Scan and proc both active: shift only
        clear_img();
        img[0] = 8'hD7;
        scan_load(build(3'b001, 5'd0, 8'h00, 8'h00));
        scan_en_n = 1'b0;
        proc_en_n = 1'b0;
        scan_in   = 1'b1;
        tick(1);
        scan_en_n = 1'b1;
        proc_en_n = 1'b1;
        scan_in   = 1'b0;
        check_regs("both", 3'b011, 5'd0, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kiwih_qtcore_tt_top.md
Name: kiwih_qtcore_tt_top

Overview:
- TinyTapeout-style top wrapping a small 8-bit accumulator CPU (qtcore-A1 class).
- CPU state: 3-bit state, 5-bit PC, 8-bit IR, 8-bit ACC, MEM_SIZE bytes of register memory.
- All of it forms one serial scan chain, so a host loads programs and reads results over 3 pins.
- Sits directly under the chip-level user-project slot; all I/O goes through io_in/io_out.

Parameters:
- MEM_SIZE, 20, number of memory bytes. Must be >=16. Scan chain length = 24 + 8*MEM_SIZE (184 by default).

Ports:
- io_in[0]  input  1  clk; the single clock, rising-edge.
- io_in[1]  input  1  rst; synchronous, active-high.
- io_in[2]  input  1  scan_enable_n; active-low, shift scan chain.
- io_in[3]  input  1  proc_en_n; active-low, CPU runs.
- io_in[4]  input  1  scan_in; serial data in.
- io_in[7:5]  input  3  unused.
- io_out[0]  output  1  halt; 1 when state==HALT.
- io_out[6:1]  output  6  MEM[15][5:0], memory-mapped output.
- io_out[7]  output  1  scan_out; chain position 183, combinational from that flop.

Behaviour:
- Priority per rising clk edge: rst > scan shift > CPU step > hold.
- rst: state=FETCH(3'b001), PC=0, IR=0, ACC=0. Memory is not reset.
- Chain vector V = {MEM[MEM_SIZE-1],...,MEM[0],ACC,IR,PC,state}, so V[2:0]=state, V[7:3]=PC, V[15:8]=IR, V[23:16]=ACC, V[31:24]=MEM[0], and so on.
- Scan shift (scan_enable_n=0): V <= {V[182:0], scan_in}. scan_out = V[183], valid before the edge.
  - 184 shifts loading MSB-first replace V entirely.
  - Captured outputs, collected MSB-first, reproduce the old V.
- CPU (proc_en_n=0, scan inactive), state one-hot:
  - FETCH(001): IR<=MEM[PC] (0 if PC>=MEM_SIZE); PC<=PC+1 (5-bit wrap); ->EXEC.
  - EXEC(010): execute IR; ->FETCH, or ->HALT on HLT.
  - HALT(100): hold until rst or scan reload.
  - Illegal state encodings go to FETCH.
- ISA, high nibble op, low nibble a/i:
  - 0 LDA: ACC=MEM[a]
  - 1 STA: MEM[a]=ACC
  - 2 ADD: ACC+=MEM[a]
  - 3 SUB: ACC-=MEM[a]
  - 4 AND: ACC&=MEM[a]
  - 5 OR: ACC|=MEM[a]
  - 6 XOR: ACC^=MEM[a]
  - 7 NOP
  - 8 JMP: PC={0,a}
  - 9 BZ: if ACC==0, PC={0,a}
  - A BNZ: if ACC!=0, PC={0,a}
  - B/C NOP
  - D LDI: ACC={0000,i}
  - E ADDI: ACC+=i
  - F0 HLT; F1 CLR (ACC=0); F2 NOT; F3 SHL; F4 SHR (logical); other F-codes NOP.
- Arithmetic is 8-bit, wraps, no flags. Memory addresses 16..MEM_SIZE-1 are reachable only by fetch and scan.
- Reset mid-instruction abandons it; memory is untouched.

Optional Feature:
- QTCORE_SHIFT_OPS_EN
  - Defined: F3/F4 perform SHL/SHR.
  - Undefined: F3/F4 are NOP and no shifter logic is built.

Decomposition:
- Package qtcore_pkg holds:
  - opcode nibble constants and F-group sub-codes;
  - state encodings ST_FETCH/ST_EXEC/ST_HALT;
  - widths PC_W=5, DATA_W=8, ADDR_W=4.
- One sub-module, scan_cell_reg (parameter WIDTH):
  - ports: clk, rst, rst_value, scan_en, scan_in, scan_out, load_en, d, q;
  - one instance per register and per memory byte, chained in V order.
- CPU datapath and control stay in the top.

Test Plan:
- Scan load: rst, then shift 184 bits with state=001, PC=1, IR=E0, ACC=01, MEM[0..4]=E0..E4 -> internal registers hold exactly those values.
- Run: proc_en for 8 clocks from the above -> ACC=0x0B, PC=5, IR=E4, state=001.
- Unload: shift 184 zeros in, capturing scan_out -> state 001, PC 05, IR E4, ACC 0B, MEM[0..4]=E0..E4.
- Program D5,1F,F0 at PC0, run 6 clocks -> io_out[6:1]=5, io_out[0]=1; extra clocks change nothing.
- Branch: ACC=0, MEM[0]=98, run 2 clocks -> PC=8; ACC=1 -> PC=1.
- Priority:
  - rst during EXEC -> next edge state 001, PC 0, ACC 0, memory unchanged;
  - scan_enable and proc_en both active -> shift only, no CPU step.
